// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad front end: scanner state
// encoding, clock-count defaults for a 50 MHz system clock and a width
// helper used for codes and counters.
package keypad_pkg;

   // Scanner FSM states.
   typedef enum logic [1:0] {
      KP_SCAN     = 2'd0,
      KP_DEBOUNCE = 2'd1,
      KP_HELD     = 2'd2,
      KP_RELEASE  = 2'd3
   } kp_state_e;

   localparam logic [1:0] S_SCAN     = KP_SCAN;
   localparam logic [1:0] S_DEBOUNCE = KP_DEBOUNCE;
   localparam logic [1:0] S_HELD     = KP_HELD;
   localparam logic [1:0] S_RELEASE  = KP_RELEASE;

   // 10 ms column dwell and 5 ms debounce window at 50 MHz.
   localparam int DEFAULT_SCAN_CYCLES     = 500000;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int code_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Small first-word fall-through FIFO for key codes. The head is forced to
// zero while empty. A push arriving while full with no pop in the same
// cycle is discarded and reported through the one-cycle drop flag.
module key_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             drop
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             do_pop;
   logic             do_push;

   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign head    = empty ? '0 : mem[rd_ptr];

   // Storage array; contents are only visible through head when non-empty.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad front end: rotates a single low column across the matrix,
// synchronises the row returns, debounces press and release of the first
// key found and queues one linear code (row*COLS + col) per press.
//
// Output handshake: key_code is valid whenever key_valid is high and stays
// stable until accepted; a code is consumed on every rising clock edge where
// key_valid and key_ready are both high. key_ready may be held high freely.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int SCAN_CYCLES     = DEFAULT_SCAN_CYCLES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int DEPTH           = 4,
   localparam int CW             = code_width(ROWS * COLS)
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic [ROWS-1:0] row_n,
   output logic [COLS-1:0] col_n,
   output logic [CW-1:0]   key_code,
   output logic            key_valid,
   input  logic            key_ready,
   output logic            key_held,
   output logic            overflow,
   input  logic            clear_overflow,
   output logic [1:0]      state_dbg
);

   localparam int SCW = code_width(SCAN_CYCLES);
   localparam int DCW = code_width(DEBOUNCE_CYCLES);
   localparam int CIW = code_width(COLS);
   localparam int RIW = code_width(ROWS);
   localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYCLES - 1);
   localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CIW-1:0] COL_LAST  = CIW'(COLS - 1);

   logic [ROWS-1:0] sync1;
   logic [ROWS-1:0] rs;
   logic [1:0]      state;
   logic [SCW-1:0]  scan_cnt;
   logic [DCW-1:0]  stable_cnt;
   logic [CIW-1:0]  col;
   logic [CIW-1:0]  next_col;
   logic [RIW-1:0]  row_sel;
   logic [RIW-1:0]  low_row;
   logic            any_low;
   logic            row_bit;
   logic            push;
   logic [CW-1:0]   push_code;
   logic            fifo_empty;
   logic            fifo_drop;

   assign col_n     = ~(COLS'(1) << col);
   assign next_col  = (col == COL_LAST) ? '0 : col + 1'b1;
   assign any_low   = ~&rs;
   assign row_bit   = rs[row_sel];
   assign push      = (state == S_DEBOUNCE) && !row_bit && (stable_cnt == DEB_LAST);
   assign push_code = CW'(int'(row_sel) * COLS + int'(col));
   assign key_held  = (state == S_HELD) || (state == S_RELEASE);
   assign key_valid = ~fifo_empty;
   assign state_dbg = state;

   // Two-flop synchroniser; idle rows read as released after reset.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1 <= '1;
         rs    <= '1;
      end else begin
         sync1 <= row_n;
         rs    <= sync1;
      end
   end

   // Lowest-index closed row, so simultaneous keys resolve deterministically.
   always_comb begin
      low_row = '0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (!rs[i]) low_row = RIW'(i);
      end
   end

   // Scan / debounce / hold / release sequencing with column and counters.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= S_SCAN;
         scan_cnt   <= '0;
         stable_cnt <= '0;
         col        <= '0;
         row_sel    <= '0;
      end else begin
         case (state)
            S_SCAN: begin
               if (scan_cnt == SCAN_LAST) begin
                  scan_cnt <= '0;
                  if (any_low) begin
                     row_sel    <= low_row;
                     stable_cnt <= '0;
                     state      <= S_DEBOUNCE;
                  end else begin
                     col <= next_col;
                  end
               end else begin
                  scan_cnt <= scan_cnt + 1'b1;
               end
            end
            S_DEBOUNCE: begin
               if (!row_bit) begin
                  if (stable_cnt == DEB_LAST) begin
                     stable_cnt <= '0;
                     state      <= S_HELD;
                  end else begin
                     stable_cnt <= stable_cnt + 1'b1;
                  end
               end else begin
                  // Closure did not hold; give up and move on.
                  stable_cnt <= '0;
                  scan_cnt   <= '0;
                  col        <= next_col;
                  state      <= S_SCAN;
               end
            end
            S_HELD: begin
               if (row_bit) begin
                  stable_cnt <= '0;
                  state      <= S_RELEASE;
               end
            end
            default: begin
               if (row_bit) begin
                  if (stable_cnt == DEB_LAST) begin
                     stable_cnt <= '0;
                     scan_cnt   <= '0;
                     col        <= next_col;
                     state      <= S_SCAN;
                  end else begin
                     stable_cnt <= stable_cnt + 1'b1;
                  end
               end else begin
                  // Release bounce: key is still down, no new code.
                  stable_cnt <= '0;
                  state      <= S_HELD;
               end
            end
         endcase
      end
   end

   // Sticky overflow; a drop in the same cycle wins over a clear.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)             overflow <= 1'b0;
      else if (fifo_drop)      overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
   end

   key_fifo #(
      .WIDTH (CW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .push      (push),
      .push_data (push_code),
      .pop       (key_valid & key_ready),
      .head      (key_code),
      .empty     (fifo_empty),
      .drop      (fifo_drop)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical key matrix drives the row lines from
// the DUT's column drive, and a queue of expected codes tracks what the
// FIFO should hold given each press and the FIFO depth.
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int ROWS            = 4;
   localparam int COLS            = 4;
   localparam int SCAN_CYCLES     = 4;
   localparam int DEBOUNCE_CYCLES = 3;
   localparam int DEPTH           = 2;
   localparam int CW              = 4;

   logic            clock = 1'b0;
   logic            resetn = 1'b0;
   logic [ROWS-1:0] row_n;
   logic [COLS-1:0] col_n;
   logic [CW-1:0]   key_code;
   logic            key_valid;
   logic            key_ready = 1'b0;
   logic            key_held;
   logic            overflow;
   logic            clear_overflow = 1'b0;
   logic [1:0]      state_dbg;

   logic [ROWS*COLS-1:0] keys = '0;
   logic [CW-1:0]        exp_q[$];
   logic                 exp_ovf = 1'b0;
   int                   n_cmp = 0;
   int                   n_err = 0;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   // Key matrix: a closed key pulls its row low while its column is driven.
   always_comb begin
      row_n = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (keys[r*COLS + c] && !col_n[c]) row_n[r] = 1'b0;
   end

   keypad_scanner #(
      .ROWS            (ROWS),
      .COLS            (COLS),
      .SCAN_CYCLES     (SCAN_CYCLES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DEPTH           (DEPTH)
   ) dut (
      .clock          (clock),
      .resetn         (resetn),
      .row_n          (row_n),
      .col_n          (col_n),
      .key_code       (key_code),
      .key_valid      (key_valid),
      .key_ready      (key_ready),
      .key_held       (key_held),
      .overflow       (overflow),
      .clear_overflow (clear_overflow),
      .state_dbg      (state_dbg)
   );

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [COLS-1:0] col_pattern(input int c);
      logic [COLS-1:0] one;
      one = 1;
      return ~(one << c);
   endfunction

   // ---------------- scoreboard model ----------------
   task automatic model_press(input int r, input int c);
      logic [CW-1:0] code;
      code = CW'(r*COLS + c);
      if (exp_q.size() < DEPTH) exp_q.push_back(code);
      else exp_ovf = 1'b1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_held(input logic want, input string tag, output int cycles);
      cycles = 0;
      while (key_held !== want && cycles < 200) begin
         @(negedge clock);
         cycles++;
      end
      check_eq(tag, key_held, want);
   endtask

   task automatic press_key(input int r, input int c, input bit bounce);
      int idx;
      idx = r*COLS + c;
      keys[idx] = 1'b1;
      if (bounce) repeat (3) begin
         repeat ($urandom_range(1, 2)) @(negedge clock);
         keys[idx] = 1'b0;
         @(negedge clock);
         keys[idx] = 1'b1;
      end
   endtask

   task automatic release_key(input int r, input int c, input bit bounce);
      int idx;
      idx = r*COLS + c;
      keys[idx] = 1'b0;
      if (bounce) repeat (3) begin
         repeat ($urandom_range(1, 2)) @(negedge clock);
         keys[idx] = 1'b1;
         @(negedge clock);
         keys[idx] = 1'b0;
      end
   endtask

   // Full press/release of one key; checks the frozen column while held.
   task automatic tap_key(input int r, input int c, input bit bounce);
      int cyc;
      press_key(r, c, bounce);
      wait_held(1'b1, "press_detect", cyc);
      model_press(r, c);
      check_eq("held_col", col_n, col_pattern(c));
      release_key(r, c, bounce);
      wait_held(1'b0, "release_detect", cyc);
      repeat (4) @(negedge clock);
   endtask

   // Pop everything with random ready, comparing the head against the model.
   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(negedge clock);
         guard++;
         check_eq({tag, "_valid"}, key_valid, 1'b1);
         check_eq({tag, "_code"}, key_code, exp_q[0]);
         key_ready = ($urandom_range(0, 2) != 0);
         if (key_ready && key_valid) void'(exp_q.pop_front());
      end
      @(negedge clock);
      key_ready = 1'b0;
      check_eq({tag, "_left"}, exp_q.size(), 0);
      check_eq({tag, "_empty_valid"}, key_valid, 1'b0);
      check_eq({tag, "_empty_code"}, key_code, 0);
   endtask

   task automatic clear_ovf();
      @(negedge clock);
      clear_overflow = 1'b1;
      @(negedge clock);
      clear_overflow = 1'b0;
      exp_ovf = 1'b0;
      check_eq("ovf_cleared", overflow, exp_ovf);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      int r;
      int c;

      // Reset values.
      repeat (3) @(negedge clock);
      check_eq("rst_col", col_n, 4'b1110);
      check_eq("rst_valid", key_valid, 1'b0);
      check_eq("rst_code", key_code, 0);
      check_eq("rst_held", key_held, 1'b0);
      check_eq("rst_ovf", overflow, 1'b0);
      resetn = 1'b1;

      // Idle rotation: column index is (cycles / SCAN_CYCLES) mod COLS.
      for (int k = 0; k < 20; k++) begin
         check_eq("rotate", col_n, col_pattern((k / SCAN_CYCLES) % COLS));
         @(negedge clock);
      end

      // Key (1,2): code 6, column frozen, release timing into column 3.
      press_key(1, 2, 1'b0);
      wait_held(1'b1, "k6_detect", cyc);
      model_press(1, 2);
      check_eq("k6_col", col_n, 4'b1011);
      check_eq("k6_valid", key_valid, 1'b1);
      check_eq("k6_code", key_code, 6);
      repeat (5) @(negedge clock);
      check_eq("k6_frozen", col_n, 4'b1011);
      check_eq("k6_still_held", key_held, 1'b1);
      release_key(1, 2, 1'b0);
      wait_held(1'b0, "k6_release", cyc);
      // 2 sync stages + 1 cycle to notice + DEBOUNCE_CYCLES stable-high.
      check_eq("k6_release_cycles", cyc, 2 + 1 + DEBOUNCE_CYCLES);
      check_eq("k6_next_col", col_n, 4'b0111);
      drain("k6");

      // Bouncy press and release still yields one code.
      tap_key(2, 1, 1'b1);
      drain("bounce");

      // Overflow: codes 0, 5, 15 into a two-entry FIFO.
      tap_key(0, 0, 1'b0);
      tap_key(1, 1, 1'b0);
      tap_key(3, 3, 1'b0);
      check_eq("ovf_set", overflow, exp_ovf);
      check_eq("ovf_model", exp_ovf, 1'b1);
      clear_ovf();
      drain("ovf");

      // Two keys in column 1: only row 0 reported; another key ignored while held.
      keys[0*COLS + 1] = 1'b1;
      keys[2*COLS + 1] = 1'b1;
      wait_held(1'b1, "multi_detect", cyc);
      model_press(0, 1);
      check_eq("multi_code", key_code, 1);
      keys[3*COLS + 3] = 1'b1;
      repeat (10) @(negedge clock);
      check_eq("multi_frozen", col_n, 4'b1101);
      check_eq("multi_held", key_held, 1'b1);
      keys = '0;
      wait_held(1'b0, "multi_release", cyc);
      repeat (20) @(negedge clock);
      drain("multi");

      // Randomised presses with random drains.
      for (int it = 0; it < 10; it++) begin
         r = $urandom_range(0, ROWS - 1);
         c = $urandom_range(0, COLS - 1);
         tap_key(r, c, bit'($urandom_range(0, 1)));
         check_eq("rnd_ovf", overflow, exp_ovf);
         if ($urandom_range(0, 2) == 0) begin
            drain("rnd");
            if (exp_ovf) clear_ovf();
         end
      end
      if (exp_ovf) clear_ovf();
      drain("rnd_final");

      // Reset mid-debounce with a code queued.
      tap_key(0, 0, 1'b0);
      keys[2*COLS + 3] = 1'b1;
      cyc = 0;
      while (state_dbg !== S_DEBOUNCE && cyc < 100) begin
         @(negedge clock);
         cyc++;
      end
      check_eq("reach_debounce", state_dbg, S_DEBOUNCE);
      resetn = 1'b0;
      exp_q.delete();
      #1;
      check_eq("mid_rst_col", col_n, 4'b1110);
      check_eq("mid_rst_valid", key_valid, 1'b0);
      check_eq("mid_rst_code", key_code, 0);
      check_eq("mid_rst_held", key_held, 1'b0);
      check_eq("mid_rst_ovf", overflow, 1'b0);
      keys = '0;
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      repeat (30) @(negedge clock);
      check_eq("post_rst_valid", key_valid, 1'b0);
      check_eq("post_rst_held", key_held, 1'b0);
      check_eq("post_rst_code", key_code, 0);

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "time limit");
   end

endmodule
